// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer.
//  - state_t     : acknowledge handshake FSM states
//  - OCW2 codes  : {R,SL,EOI} command encodings
//  - SPURIOUS_LEVEL and a one-hot to level encoder
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ACK1 = 3'd1,
        ACK1      = 3'd2,
        WAIT_ACK2 = 3'd3,
        ACK2      = 3'd4
    } state_t;

    localparam logic [2:0] NS_EOI        = 3'b001;
    localparam logic [2:0] S_EOI         = 3'b011;
    localparam logic [2:0] ROT_NS_EOI    = 3'b101;
    localparam logic [2:0] ROT_S_EOI     = 3'b111;
    localparam logic [2:0] SET_PRI       = 3'b110;
    localparam logic [2:0] ROT_AEOI_SET  = 3'b100;
    localparam logic [2:0] ROT_AEOI_CLR  = 3'b000;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Convert the resolver's one-hot winner into a level number.
    function automatic logic [2:0] onehot_to_level(input logic [7:0] v);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                lvl = 3'(k);
            end else begin
                lvl = lvl;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_finder.sv
// Highest-priority in-service level finder.
//  isr_i    : in-service register
//  rotate_i : level currently holding highest priority
//  level_o  : first set ISR bit searching upward from rotate_i (mod 8)
//  found_o  : 1 when any ISR bit is set
module isr_priority_finder (
    input  logic [7:0] isr_i,
    input  logic [2:0] rotate_i,
    output logic [2:0] level_o,
    output logic       found_o
);

    logic [2:0] idx_s;

    // Scan priority order starting at rotate_i; first hit is the winner.
    always_comb begin
        level_o = 3'd0;
        found_o = 1'b0;
        idx_s   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx_s = rotate_i + 3'(k);
            if (!found_o && isr_i[idx_s]) begin
                found_o = 1'b1;
                level_o = idx_s;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt acknowledge sequencer (8086 two-pulse INTA handshake).
//  clk, rst             : clock, async active-high reset
//  interrupt            : one-hot resolved request (0 = none)
//  inta_n               : synchronized interrupt acknowledge (active low)
//  ocw2_valid/cmd/level : OCW2 write strobe, {R,SL,EOI}, L2..L0
//  aeoi_config          : auto-EOI mode
//  vector_base          : T7..T3
//  int_out              : INT to CPU
//  in_service_register  : ISR
//  clear_irr            : one-cycle IRR clear pulse
//  priority_rotate      : highest-priority level for the resolver
//  data_out/_en         : vector byte and bus enable
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic       ocw2_valid,
    input  logic [2:0] ocw2_cmd,
    input  logic [2:0] ocw2_level,
    input  logic       aeoi_config,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] clear_irr,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    state_t     state_q;
    logic       int_out_q, inta_n_q, spurious_q, rotate_in_aeoi_q, rotate_in_aeoi_d;
    logic       data_out_en_q;
    logic [7:0] isr_q, isr_d, clear_irr_q, data_out_q;
    logic [2:0] rotate_q, rotate_d, acked_level_q;
    logic       inta_fall_s, inta_rise_s, ack_set_en_s, aeoi_fire_s, found_s;
    logic [2:0] hp_level_s;
    logic [7:0] ack_set_s;

    isr_priority_finder u_finder (
        .isr_i    (isr_q),
        .rotate_i (rotate_q),
        .level_o  (hp_level_s),
        .found_o  (found_s)
    );

    assign inta_fall_s  = inta_n_q & ~inta_n;
    assign inta_rise_s  = ~inta_n_q & inta_n;
    assign ack_set_en_s = (state_q == WAIT_ACK1) && inta_fall_s && (interrupt != 8'h00);
    assign ack_set_s    = ack_set_en_s ? interrupt : 8'h00;
    assign aeoi_fire_s  = (state_q == ACK2) && inta_rise_s && aeoi_config && !spurious_q;

    // Next ISR / rotation: clears use the current ISR, the INTA set is ORed
    // last so it wins on the same bit; OCW2 rotation overrides AEOI rotation.
    always_comb begin
        isr_d            = isr_q;
        rotate_d         = rotate_q;
        rotate_in_aeoi_d = rotate_in_aeoi_q;
        if (aeoi_fire_s) begin
            isr_d[acked_level_q] = 1'b0;
            if (rotate_in_aeoi_q) begin
                rotate_d = acked_level_q + 3'd1;
            end else begin
                rotate_d = rotate_q;
            end
        end else begin
            isr_d = isr_q;
        end
        if (ocw2_valid) begin
            case (ocw2_cmd)
                NS_EOI: begin
                    if (found_s) begin
                        isr_d[hp_level_s] = 1'b0;
                    end else begin
                        isr_d = isr_d;
                    end
                end
                S_EOI: isr_d[ocw2_level] = 1'b0;
                ROT_NS_EOI: begin
                    if (found_s) begin
                        isr_d[hp_level_s] = 1'b0;
                        rotate_d          = hp_level_s + 3'd1;
                    end else begin
                        isr_d = isr_d;
                    end
                end
                ROT_S_EOI: begin
                    isr_d[ocw2_level] = 1'b0;
                    rotate_d          = ocw2_level + 3'd1;
                end
                SET_PRI:      rotate_d         = ocw2_level + 3'd1;
                ROT_AEOI_SET: rotate_in_aeoi_d = 1'b1;
                ROT_AEOI_CLR: rotate_in_aeoi_d = 1'b0;
                default:      isr_d            = isr_d;
            endcase
        end else begin
            isr_d = isr_d;
        end
        isr_d = isr_d | ack_set_s;
    end

    // Handshake FSM with registered outputs and ISR/rotation state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            int_out_q        <= 1'b0;
            inta_n_q         <= 1'b1;
            spurious_q       <= 1'b0;
            rotate_in_aeoi_q <= 1'b0;
            data_out_en_q    <= 1'b0;
            isr_q            <= 8'h00;
            clear_irr_q      <= 8'h00;
            data_out_q       <= 8'h00;
            rotate_q         <= 3'd0;
            acked_level_q    <= 3'd0;
        end else begin
            inta_n_q         <= inta_n;
            isr_q            <= isr_d;
            rotate_q         <= rotate_d;
            rotate_in_aeoi_q <= rotate_in_aeoi_d;
            clear_irr_q      <= 8'h00;
            case (state_q)
                IDLE: begin
                    if (interrupt != 8'h00) begin
                        int_out_q <= 1'b1;
                        state_q   <= WAIT_ACK1;
                    end
                end
                WAIT_ACK1: begin
                    if (inta_fall_s) begin
                        int_out_q <= 1'b0;
                        state_q   <= ACK1;
                        if (interrupt != 8'h00) begin
                            acked_level_q <= onehot_to_level(interrupt);
                            clear_irr_q   <= interrupt;
                            spurious_q    <= 1'b0;
                        end else begin
                            acked_level_q <= SPURIOUS_LEVEL;
                            spurious_q    <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (inta_rise_s) begin
                        state_q <= WAIT_ACK2;
                    end
                end
                WAIT_ACK2: begin
                    if (inta_fall_s) begin
                        state_q       <= ACK2;
                        data_out_q    <= {vector_base, acked_level_q};
                        data_out_en_q <= 1'b1;
                    end
                end
                ACK2: begin
                    if (inta_rise_s) begin
                        data_out_en_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    int_out_q     <= 1'b0;
                    data_out_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_out             = int_out_q;
    assign in_service_register = isr_q;
    assign clear_irr           = clear_irr_q;
    assign priority_rotate     = rotate_q;
    assign data_out            = data_out_q;
    assign data_out_en         = data_out_en_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] interrupt;
    logic       inta_n;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd, ocw2_level;
    logic       aeoi_config;
    logic [4:0] vector_base;
    logic       int_out, data_out_en;
    logic [7:0] in_service_register, clear_irr, data_out;
    logic [2:0] priority_rotate;

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .interrupt(interrupt), .inta_n(inta_n),
        .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
        .aeoi_config(aeoi_config), .vector_base(vector_base),
        .int_out(int_out), .in_service_register(in_service_register),
        .clear_irr(clear_irr), .priority_rotate(priority_rotate),
        .data_out(data_out), .data_out_en(data_out_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [7:0] m_isr   = 8'h00;
    logic [2:0] m_rot   = 3'd0;
    bit         m_raeoi = 1'b0;

    // scoreboard queues
    logic [7:0] exp_clr[$];
    logic [7:0] exp_vec[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare whenever the DUT pulses clear_irr or starts driving the bus.
    logic den_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                den_prev = 1'b0;
            end else begin
                if (clear_irr != 8'h00) begin
                    if (exp_clr.size() == 0) chk("clear_irr_unexpected", clear_irr, 8'h00);
                    else chk("clear_irr", clear_irr, exp_clr.pop_front());
                end
                if (data_out_en && !den_prev) begin
                    if (exp_vec.size() == 0) chk("data_out_en_unexpected", data_out_en, 1'b0);
                    else chk("vector", data_out, exp_vec.pop_front());
                end
                den_prev = data_out_en;
            end
        end
    end

    // OCW2 semantics, from the command table: search ISR from m_rot upward.
    task automatic model_ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
        int h = -1;
        for (int k = 0; k < 8; k++) begin
            int b = (int'(m_rot) + k) % 8;
            if (h < 0 && m_isr[b]) h = b;
        end
        case (cmd)
            3'b001: if (h >= 0) m_isr[h] = 1'b0;
            3'b011: m_isr[lvl] = 1'b0;
            3'b101: if (h >= 0) begin m_isr[h] = 1'b0; m_rot = 3'((h + 1) % 8); end
            3'b111: begin m_isr[lvl] = 1'b0; m_rot = 3'((int'(lvl) + 1) % 8); end
            3'b110: m_rot = 3'((int'(lvl) + 1) % 8);
            3'b100: m_raeoi = 1'b1;
            3'b000: m_raeoi = 1'b0;
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_isr"}, in_service_register, m_isr);
        chk({tag, "_rot"}, priority_rotate, m_rot);
    endtask

    task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
        ocw2_valid = 1'b1; ocw2_cmd = cmd; ocw2_level = lvl;
        model_ocw2(cmd, lvl);
        step(1);
        ocw2_valid = 1'b0;
        step(1);
        check_state("ocw2");
    endtask

    task automatic wait_int();
        int n = 0;
        while (int_out !== 1'b1 && n < 10) begin step(1); n++; end
        chk("int_out_raise", int_out, 1'b1);
    endtask

    // Full two-pulse acknowledge; optional OCW2 written in the first-fall cycle.
    task automatic ack_cycle(input logic [7:0] irq, input bit spur, input bit do_ocw,
                             input logic [2:0] ocmd, input logic [2:0] olvl);
        logic [2:0] lvl;
        bit sp;
        interrupt = spur ? 8'h01 : irq;
        wait_int();
        if (spur) begin
            interrupt = 8'h00;
            step(2);
            chk("int_held", int_out, 1'b1);
        end
        inta_n = 1'b0;
        if (do_ocw) begin
            ocw2_valid = 1'b1; ocw2_cmd = ocmd; ocw2_level = olvl;
            model_ocw2(ocmd, olvl);
        end
        sp  = (interrupt == 8'h00);
        lvl = 3'd7;
        if (!sp) begin
            for (int k = 0; k < 8; k++) if (interrupt[k]) lvl = 3'(k);
            m_isr[lvl] = 1'b1;
            exp_clr.push_back(interrupt);
        end
        step(1);
        ocw2_valid = 1'b0;
        interrupt  = 8'h00;
        step(1);
        chk("int_out_drop", int_out, 1'b0);
        check_state("ack1");
        inta_n = 1'b1;
        step(3);
        inta_n = 1'b0;
        exp_vec.push_back({vector_base, lvl});
        step(3);
        chk("data_out_en_ack2", data_out_en, 1'b1);
        inta_n = 1'b1;
        if (aeoi_config && !sp) begin
            m_isr[lvl] = 1'b0;
            if (m_raeoi) m_rot = lvl + 3'd1;
        end
        step(3);
        chk("data_out_en_idle", data_out_en, 1'b0);
        check_state("ack_end");
    endtask

    initial begin
        rst = 1'b1; interrupt = 8'h00; inta_n = 1'b1; ocw2_valid = 1'b0;
        ocw2_cmd = 3'd0; ocw2_level = 3'd0; aeoi_config = 1'b0; vector_base = 5'h00;
        step(2);
        chk("rst_int_out", int_out, 1'b0);
        chk("rst_isr", in_service_register, 8'h00);
        chk("rst_clear_irr", clear_irr, 8'h00);
        chk("rst_rot", priority_rotate, 3'd0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_out_en", data_out_en, 1'b0);
        rst = 1'b0;
        step(2);

        // normal cycle: expect vector 8'h8B
        vector_base = 5'h11;
        ack_cycle(8'h08, 1'b0, 1'b0, 3'd0, 3'd0);
        ocw2(3'b011, 3'd3);

        // AEOI with rotation, wrap 7+1 -> 0
        ocw2(3'b110, 3'd2);
        ocw2(3'b100, 3'd0);
        aeoi_config = 1'b1;
        ack_cycle(8'h80, 1'b0, 1'b0, 3'd0, 3'd0);
        aeoi_config = 1'b0;
        ocw2(3'b000, 3'd0);

        // rotating non-specific EOI from ISR=8'h24, rotate 0
        ocw2(3'b110, 3'd7);
        ack_cycle(8'h04, 1'b0, 1'b0, 3'd0, 3'd0);
        ack_cycle(8'h20, 1'b0, 1'b0, 3'd0, 3'd0);
        ocw2(3'b101, 3'd0);
        ocw2(3'b101, 3'd0);

        // spurious
        vector_base = 5'h0A;
        ack_cycle(8'h00, 1'b1, 1'b0, 3'd0, 3'd0);

        // collisions
        ack_cycle(8'h02, 1'b0, 1'b1, 3'b011, 3'd1);
        ocw2(3'b011, 3'd1);
        ack_cycle(8'h10, 1'b0, 1'b0, 3'd0, 3'd0);
        ack_cycle(8'h02, 1'b0, 1'b1, 3'b011, 3'd4);

        // randomized mix
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) < 2) begin
                aeoi_config = 1'($urandom_range(0, 1));
                vector_base = 5'($urandom_range(0, 31));
                ack_cycle(8'h01 << $urandom_range(0, 7), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end else begin
                ocw2(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end
        aeoi_config = 1'b0;

        // reset in WAIT_ACK2 with ISR=8'h01, rotate 5
        ocw2(3'b011, 3'd0); ocw2(3'b011, 3'd1); ocw2(3'b011, 3'd2); ocw2(3'b011, 3'd3);
        ocw2(3'b011, 3'd4); ocw2(3'b011, 3'd5); ocw2(3'b011, 3'd6); ocw2(3'b011, 3'd7);
        ocw2(3'b110, 3'd4);
        interrupt = 8'h01;
        wait_int();
        inta_n = 1'b0;
        m_isr[0] = 1'b1;
        exp_clr.push_back(8'h01);
        step(1);
        interrupt = 8'h00;
        step(1);
        inta_n = 1'b1;
        step(3);
        check_state("pre_rst");
        rst = 1'b1;
        m_isr = 8'h00; m_rot = 3'd0; m_raeoi = 1'b0;
        #1;
        chk("midrst_int_out", int_out, 1'b0);
        chk("midrst_isr", in_service_register, 8'h00);
        chk("midrst_rot", priority_rotate, 3'd0);
        chk("midrst_data_out", data_out, 8'h00);
        chk("midrst_data_out_en", data_out_en, 1'b0);
        step(2);
        rst = 1'b0;
        step(1);
        for (int p = 0; p < 3; p++) begin
            inta_n = 1'b0; step(2);
            inta_n = 1'b1; step(2);
        end
        chk("stray_data_out_en", data_out_en, 1'b0);
        chk("stray_int_out", int_out, 1'b0);
        check_state("stray");

        chk("clr_queue_empty", exp_clr.size(), 0);
        chk("vec_queue_empty", exp_vec.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the PIC's interrupt acknowledge cycle around the priority resolver.
- Raises INT from the resolver's one-hot winner and runs the 8086-mode two-pulse INTA handshake.
- Sets and clears the In-Service Register (ISR), pulses IRR clears and drives the vector byte.
- Executes OCW2 EOI/rotation commands and owns the priority_rotate value fed back to the resolver.

Parameters:
- NUM_IR, 8, number of interrupt request lines (fixed at 8; widths below assume 8).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- interrupt  input  8  one-hot resolved request from the priority resolver (0 = none).
- inta_n  input  1  interrupt acknowledge, active low, already synchronized to clk.
- ocw2_valid  input  1  one-cycle strobe: OCW2 written.
- ocw2_cmd  input  3  OCW2 {R,SL,EOI}.
- ocw2_level  input  3  OCW2 L2..L0.
- aeoi_config  input  1  auto-EOI mode (from ICW4).
- vector_base  input  5  T7..T3 (from ICW2).
- int_out  output  1  INT pin to CPU.
- in_service_register  output  8  ISR, fed to resolver.
- clear_irr  output  8  one-cycle pulse: clear this IRR bit.
- priority_rotate  output  3  level with highest priority (resolver rotate amount).
- data_out  output  8  vector byte.
- data_out_en  output  1  drive data bus.

Behaviour:
- Reset (async, rst=1): state IDLE, int_out=0, ISR=0, clear_irr=0, priority_rotate=0, data_out=0, data_out_en=0, rotate_in_aeoi flag=0, acked_level=0.
- inta falling edge = inta_n registered 1, now 0. Rising edge = registered 0, now 1. Edge detection adds one cycle of latency.
- FSM:
  - IDLE: if interrupt!=0, set int_out=1 next cycle and go to WAIT_ACK1.
  - WAIT_ACK1: int_out held at 1 even if interrupt drops. On falling edge:
    - interrupt!=0: acked_level=encode(interrupt), set ISR[acked_level], clear_irr=interrupt for one cycle.
    - interrupt==0 (spurious): acked_level=7, ISR unchanged, clear_irr=0.
    - In both cases int_out=0; go to ACK1.
  - ACK1: on rising edge go to WAIT_ACK2.
  - WAIT_ACK2: on falling edge go to ACK2.
  - ACK2: data_out={vector_base,acked_level}, data_out_en=1 while in ACK2. On rising edge:
    - data_out_en=0.
    - If aeoi_config and not spurious: clear ISR[acked_level]; if rotate_in_aeoi, priority_rotate=acked_level+1 (mod 8).
    - Go to IDLE.
  - IDLE re-evaluates interrupt the cycle after returning.
- OCW2 (ocw2_valid=1), independent of FSM state:
  - 001 non-specific EOI: clear the highest-priority set ISR bit, searching from priority_rotate upward mod 8. No-op if ISR=0.
  - 011 specific EOI: clear ISR[ocw2_level].
  - 101 rotate on non-specific EOI: clear the highest-priority bit H; priority_rotate=H+1. If ISR=0, nothing changes.
  - 111 rotate on specific EOI: clear ISR[L]; priority_rotate=L+1.
  - 110 set priority: priority_rotate=L+1; ISR unchanged.
  - 100 sets rotate_in_aeoi; 000 clears it; 010 no-op.
- Simultaneous ISR set (first INTA) and OCW2 clear in one cycle:
  - Clear is computed from the current ISR, then the set is ORed in, so the set wins on the same bit.
  - When both OCW2 and AEOI rotate fire in one cycle, the OCW2 write of priority_rotate wins.
- Wrap-around: all level+1 arithmetic is 3-bit modulo 8 (7+1 = 0).
- rst asserted mid-handshake returns to the reset state immediately. Further INTA edges are ignored until IDLE raises a new INT.

Decomposition:
- Shared package/include holds:
  - FSM state localparams: IDLE, WAIT_ACK1, ACK1, WAIT_ACK2, ACK2.
  - OCW2 command codes (NS_EOI=3'b001, S_EOI=3'b011, ROT_NS_EOI=3'b101, ROT_S_EOI=3'b111, SET_PRI=3'b110, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000).
  - SPURIOUS_LEVEL=3'd7.
- One sub-module: isr_priority_finder. Inputs ISR and rotate; outputs a 3-bit highest-priority level plus a found flag. It is combinational and reused by both non-specific EOI paths.

Test Plan:
- Normal cycle: interrupt=8'h08, vector_base=5'h11, two INTA pulses -> int_out rises; at first fall ISR=8'h08, clear_irr=8'h08 for one cycle, int_out=0; during second pulse data_out=8'h8B, data_out_en=1; back in IDLE.
- AEOI with rotation: aeoi_config=1, OCW2 100, then a full cycle on interrupt=8'h80 -> ISR returns to 0 after second INTA rising edge; priority_rotate=0 (wrap).
- Rotating non-specific EOI: ISR=8'h24, priority_rotate=0, OCW2 101 -> ISR=8'h20, priority_rotate=3; repeat -> ISR=0, priority_rotate=6.
- Spurious: interrupt withdrawn to 0 before first INTA -> ISR unchanged, clear_irr=0, second pulse data_out={vector_base,3'd7}.
- Collision: first INTA fall for interrupt=8'h02 in the same cycle as OCW2 011 L=1 -> ISR[1]=1 afterwards; separately, specific EOI L=4 concurrent with a set of bit 1 -> bit 4 cleared, bit 1 set.
- Reset mid-handshake: rst during WAIT_ACK2 with ISR=8'h01, priority_rotate=5 -> all outputs 0 asynchronously; a stray INTA afterwards does not change ISR or data_out_en.
